// File: rtl/race_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : race_launcher
//  Description : Challenge-side controller for a delay-based PUF race. Drives
//                the challenge onto both delay chains, settles the arbiter in
//                reset, fires a launch edge, samples the synchronized winner
//                and returns a response bit over a valid/ready handshake.
//                Optional majority voting over several races is compiled in
//                with the macro RACE_LAUNCHER_VOTE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module race_launcher #(
    parameter int CHAL_W         = 64,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int VOTES          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chal_valid,
    input  logic [CHAL_W-1:0] chal_data,
    output logic              chal_ready,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    output logic              arb_reset,
    input  logic              arb_done,
    input  logic              arb_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_bit,
    output logic [3:0]        resp_ones,
    output logic              resp_timeout
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load    = 3'd1;
    localparam logic [2:0] c_st_fire    = 3'd2;
    localparam logic [2:0] c_st_sample  = 3'd3;
    localparam logic [2:0] c_st_recover = 3'd4;
    localparam logic [2:0] c_st_resp    = 3'd5;

`ifdef RACE_LAUNCHER_VOTE_EN
    localparam int c_races_per_chal = VOTES;
`else
    // Exactly one race per challenge; VOTES has no effect in this build.
    localparam int c_races_per_chal = (VOTES > 0) ? 1 : 1;
`endif

    localparam logic [3:0] c_races       = 4'(c_races_per_chal);
    localparam logic [3:0] c_half        = 4'(c_races_per_chal / 2);
    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_fire_last   = 8'(TIMEOUT_CYCLES - 1);

    // Synchronizer stages for the asynchronous arbiter signals
    logic done_meta_q, done_meta_d, done_s_q, done_s_d;
    logic out_meta_q,  out_meta_d,  out_s_q,  out_s_d;

    // Control state
    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        races_q, races_d;
    logic [3:0]        ones_q, ones_d;
    logic              timeout_q, timeout_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              take_chal;

    // Registered outputs
    logic chal_ready_q, chal_ready_d;
    logic launch_q, launch_d;
    logic arb_reset_q, arb_reset_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_bit_q, resp_bit_d;

    // Two-flop synchronizer next-state
    always_comb begin
        done_meta_d = arb_done;
        done_s_d    = done_meta_q;
        out_meta_d  = arb_out;
        out_s_d     = out_meta_q;
    end

    // Synchronizer flops, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
            out_meta_q  <= 1'b0;
            out_s_q     <= 1'b0;
        end else begin
            done_meta_q <= done_meta_d;
            done_s_q    <= done_s_d;
            out_meta_q  <= out_meta_d;
            out_s_q     <= out_s_d;
        end
    end

    // Race sequencing: next state, phase counter, vote tally and output values
    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        races_d   = races_q;
        ones_d    = ones_q;
        timeout_d = timeout_q;
        take_chal = (state_q == c_st_idle) && chal_valid && chal_ready_q;

        case (state_q)
            c_st_idle: begin
                if (take_chal) begin
                    chal_d    = chal_data;
                    races_d   = 4'd0;
                    ones_d    = 4'd0;
                    timeout_d = 1'b0;
                    state_d   = c_st_load;
                end
            end
            c_st_load: begin
                if (cnt_q == c_settle_last) begin
                    state_d = c_st_fire;
                end
            end
            c_st_fire: begin
                // A late done still wins over an expiring timeout in the same cycle
                if (done_s_q) begin
                    state_d = c_st_sample;
                end else if (cnt_q == c_fire_last) begin
                    timeout_d = 1'b1;
                    state_d   = c_st_recover;
                end
            end
            c_st_sample: begin
                if (out_s_q && (ones_q != 4'hF)) begin
                    ones_d = ones_q + 4'd1;
                end
                races_d = races_q + 4'd1;
                state_d = c_st_recover;
            end
            c_st_recover: begin
                if (cnt_q == c_settle_last) begin
                    if ((races_q < c_races) && !timeout_q) begin
                        state_d = c_st_load;
                    end else begin
                        state_d = c_st_resp;
                    end
                end
            end
            c_st_resp: begin
                if (resp_ready) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Phase counter restarts on every state change and idles at zero
        if ((state_d != state_q) || (state_q == c_st_idle) || (state_q == c_st_resp)) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Outputs are registered from the state being entered so they line up with it
        chal_ready_d = (state_d == c_st_idle);
        launch_d     = (state_d == c_st_fire) || (state_d == c_st_sample);
        arb_reset_d  = !launch_d;
        resp_valid_d = (state_d == c_st_resp);
        resp_bit_d   = !timeout_d && (ones_d > c_half);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_st_idle;
            cnt_q        <= 8'd0;
            races_q      <= 4'd0;
            ones_q       <= 4'd0;
            timeout_q    <= 1'b0;
            chal_q       <= '0;
            chal_ready_q <= 1'b0;
            launch_q     <= 1'b0;
            arb_reset_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            races_q      <= races_d;
            ones_q       <= ones_d;
            timeout_q    <= timeout_d;
            chal_q       <= chal_d;
            chal_ready_q <= chal_ready_d;
            launch_q     <= launch_d;
            arb_reset_q  <= arb_reset_d;
            resp_valid_q <= resp_valid_d;
            resp_bit_q   <= resp_bit_d;
        end
    end

    assign chal_ready   = chal_ready_q;
    assign chal_out     = chal_q;
    assign launch       = launch_q;
    assign arb_reset    = arb_reset_q;
    assign resp_valid   = resp_valid_q;
    assign resp_bit     = resp_bit_q;
    assign resp_ones    = ones_q;
    assign resp_timeout = timeout_q;

endmodule
`default_nettype wire
